truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequential equivalence sweeper for small combinational logic functions. It drives every input combination of an N_IN-input function onto a shared vector bus and samples the outputs of N_IMPL parallel implementations (gate-level SOP, POS, Karnaugh, operator forms) after a settle delay. It captures the golden truth table from implementation 0 and counts its minterms. It also records the first vector where any other implementation disagrees with implementation 0.

## Interface
- N_IN, 3: function input width; legal 1..8; rows = 2**N_IN
- N_IMPL, 3: number of implementations compared; legal 1..8; bit 0 is golden
- SETTLE, 1: extra hold cycles per vector before sampling; legal 0..15

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin sweep; accepted only in IDLE
- stop_on_mismatch  in  1  mode, latched at start: end sweep at first mismatch
- y_in  in  N_IMPL  implementation outputs, combinational from vec
- vec  out  N_IN  current input combination driven to all implementations
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  no mismatch in last sweep; held until next start
- minterm_cnt  out  N_IN+1  count of rows where y_in[0]=1
- truth_table  out  2**N_IN  bit k = y_in[0] sampled at vec=k
- mismatch_vec  out  N_IN  first mismatching vector
- mismatch_mask  out  N_IMPL  y_in ^ {N_IMPL{y_in[0]}} at first mismatch; bit 0 always 0

## Operation
- FSM states: IDLE, HOLD, DONE.
- IDLE, start=1:
  - clear minterm_cnt, truth_table, mismatch_vec, mismatch_mask, pass
  - vec <= 0, settle counter <= 0, latch stop_on_mismatch
  - go to HOLD
- HOLD, counter < SETTLE: counter++.
- HOLD, counter == SETTLE (sample edge):
  - write y_in[0] into truth_table[vec]; minterm_cnt += y_in[0]
  - mismatch = |(y_in[N_IMPL-1:1] ^ replicated y_in[0]). On the first mismatch, store vec and mask; later mismatches are not recorded.
  - go to DONE if vec == rows-1, or if a mismatch occurs with the stop mode latched
  - otherwise vec++ and counter <= 0
- DONE: done=1 for one cycle; pass <= no mismatch recorded; then go to IDLE.
- start is ignored in HOLD and DONE.
- N_IMPL=1: mismatch is never possible; pass=1 after every sweep.
- Early stop: unsampled truth_table bits stay 0; minterm_cnt covers sampled rows only.
- vec holds its last value after the sweep until the next start.

## Timing
- Reset (async, any state, including mid-sweep): FSM=IDLE; every output is 0 (vec, busy, done, pass, minterm_cnt, truth_table, mismatch_vec, mismatch_mask).
- start sampled at edge t0:
  - busy=1 and vec=0 from t0 onward
  - row k is sampled at edge t0+(k+1)(SETTLE+1)
- Full sweep: busy high for rows*(SETTLE+1) cycles. done is high in the single cycle after the last sample edge; busy is 0 in that cycle.
- Defaults (3 inputs, SETTLE=1): 16 busy cycles; done in cycle 17 after start.
- y_in must be stable within SETTLE+1 cycles of a vec change; no internal synchronisation is applied.
- minterm_cnt width N_IN+1 holds the full count 2**N_IN without overflow.

## Structure
- Package truth_table_sweeper_pkg: state enum (IDLE, HOLD, DONE) and SETTLE_MAX=15 constant.
- Sub-module sweep_counter:
  - settle counter plus vector counter
  - outputs sample_en and last_row
- Top level holds the FSM, result registers and the mismatch compare.

## Test plan
All scenarios use default parameters and vec={A,B,C}, A as MSB. Golden y_in[0] = ~A&C | B&C.
- All impls equal golden, start pulse -> 16 busy cycles, done in cycle 17, truth_table=8'h8A, minterm_cnt=3, pass=1, mismatch_vec=0, mismatch_mask=0.
- Impl 1 true only at vec 3 and 7, impl 2 correct, stop_on_mismatch=0 -> full sweep, pass=0, mismatch_vec=1, mismatch_mask=3'b010, truth_table=8'h8A.
- Same stimulus, stop_on_mismatch=1 -> done after sampling vec 1 (cycle 5), truth_table=8'h02, minterm_cnt=1, pass=0.
- rst_n low mid-sweep at vec=4 -> all outputs 0 immediately; new start after release runs a clean full sweep with the scenario-1 results.
- start pulsed while busy and during done -> ignored; results equal a single uninterrupted sweep.
- N_IN=1, N_IMPL=1, SETTLE=0, y_in[0]=vec -> busy 2 cycles, truth_table=2'b10, minterm_cnt=1, pass=1.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared state encoding and settle-counter sizing for the truth-table sweeper.
package truth_table_sweeper_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = $clog2(SETTLE_MAX + 1);
endpackage

// File: rtl/truth_table_sweeper_sweep_counter.sv
// Settle counter plus input-vector counter; sample_en fires on the last hold cycle of a row.
// Latency: one row per SETTLE+1 cycles; no backpressure, advance is decided by the parent.
module sweep_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            run,
  input  logic            advance,
  output logic [N_IN-1:0] vec,
  output logic            sample_en,
  output logic            last_row
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  vec_q, vec_d;

  assign sample_en = run && (cnt_q == CNT_W'(SETTLE));
  assign last_row  = &vec_q;
  assign vec       = vec_q;

  // A sample without advance (sweep end) freezes both counters.
  always_comb begin
    cnt_d = cnt_q;
    vec_d = vec_q;
    if (clear) begin
      cnt_d = '0;
      vec_d = '0;
    end else if (advance) begin
      cnt_d = '0;
      vec_d = vec_q + N_IN'(1);
    end else if (run && !sample_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      vec_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vec_q <= vec_d;
    end
  end
endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all input vectors, captures implementation 0 as golden and records the first disagreement.
// Latency: rows*(SETTLE+1) busy cycles then a one-cycle done; start is ignored while not idle.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_IMPL = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop_on_mismatch,
  input  logic [N_IMPL-1:0]    y_in,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        minterm_cnt,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN-1:0]      mismatch_vec,
  output logic [N_IMPL-1:0]    mismatch_mask
);
  localparam int CW = N_IN + 1;

  state_e              state_q, state_d;
  logic                stop_q, stop_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_IN:0]       mint_q, mint_d;
  logic [2**N_IN-1:0]  tt_q, tt_d;
  logic [N_IN-1:0]     mvec_q, mvec_d;
  logic [N_IMPL-1:0]   mmask_q, mmask_d;

  logic                sample_en, last_row, clear, run, advance, finish;
  logic [N_IMPL-1:0]   diff;
  logic                mismatch, recorded;

  // Bit 0 of diff is always 0, so a nonzero stored mask doubles as the "already recorded" flag.
  assign diff     = y_in ^ {N_IMPL{y_in[0]}};
  assign mismatch = |diff;
  assign recorded = |mmask_q;

  assign clear   = (state_q == IDLE) && start;
  assign run     = (state_q == HOLD);
  assign finish  = sample_en && (last_row || (mismatch && stop_q));
  assign advance = sample_en && !finish;

  sweep_counter #(.N_IN(N_IN), .SETTLE(SETTLE)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .run       (run),
    .advance   (advance),
    .vec       (vec),
    .sample_en (sample_en),
    .last_row  (last_row)
  );

  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
    pass_d  = pass_q;
    mint_d  = mint_q;
    tt_d    = tt_q;
    mvec_d  = mvec_q;
    mmask_d = mmask_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = HOLD;
        stop_d  = stop_on_mismatch;
        pass_d  = 1'b0;
        mint_d  = '0;
        tt_d    = '0;
        mvec_d  = '0;
        mmask_d = '0;
      end
      HOLD: if (sample_en) begin
        tt_d[vec] = y_in[0];
        mint_d    = mint_q + CW'(y_in[0]);
        if (mismatch && !recorded) begin
          mvec_d  = vec;
          mmask_d = diff;
        end
        if (finish) begin
          state_d = DONE;
          pass_d  = !(mismatch || recorded);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == HOLD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mint_q  <= '0;
      tt_q    <= '0;
      mvec_q  <= '0;
      mmask_q <= '0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mint_q  <= mint_d;
      tt_q    <= tt_d;
      mvec_q  <= mvec_d;
      mmask_q <= mmask_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign minterm_cnt   = mint_q;
  assign truth_table   = tt_q;
  assign mismatch_vec  = mvec_q;
  assign mismatch_mask = mmask_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: per-cycle comparison against a row-table model, plus literal checks per scenario.
module tb_truth_table_sweeper;
  logic       clk = 1'b0;
  logic       rst_n, start, stop_on_mismatch;
  logic [2:0] y_in, vec, mismatch_vec, mismatch_mask;
  logic       busy, done, pass;
  logic [3:0] minterm_cnt;
  logic [7:0] truth_table;

  logic       start_s, stop_s;
  logic [0:0] y_s, vec_s, mvec_s, mmask_s;
  logic       busy_s, done_s, pass_s;
  logic [1:0] mint_s, tt_s;

  int vectors = 0, miscompares = 0;
  int mode = 0;

  always #5 clk = ~clk;

  truth_table_sweeper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_on_mismatch(stop_on_mismatch),
    .y_in(y_in), .vec(vec), .busy(busy), .done(done), .pass(pass),
    .minterm_cnt(minterm_cnt), .truth_table(truth_table),
    .mismatch_vec(mismatch_vec), .mismatch_mask(mismatch_mask)
  );

  truth_table_sweeper #(.N_IN(1), .N_IMPL(1), .SETTLE(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .stop_on_mismatch(stop_s),
    .y_in(y_s), .vec(vec_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .minterm_cnt(mint_s), .truth_table(tt_s),
    .mismatch_vec(mvec_s), .mismatch_mask(mmask_s)
  );

  // Stimulus implementations: {impl2, impl1, golden}, golden = ~A&C | B&C.
  function automatic logic [2:0] impl_y(input int m, input logic [2:0] v);
    logic g, i1, i2;
    g  = (~v[2] & v[0]) | (v[1] & v[0]);
    i1 = (v == 3'd3) || (v == 3'd7);
    i2 = g ^ (v == 3'd6);
    case (m)
      1:       return {g, i1, g};
      2:       return {i2, g, g};
      default: return {g, g, g};
    endcase
  endfunction

  assign y_s = vec_s;
  always_comb y_in = impl_y(mode, vec);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per-row golden bits, first mismatching row, number of rows the sweep samples.
  logic       y0_m[8];
  int         first_mm, n_rows;
  logic [2:0] mm_mask_m;
  logic       pass_m;

  task automatic compute_model(input int m, input logic st);
    logic [2:0] y, df;
    first_mm = 99;
    mm_mask_m = '0;
    for (int r = 0; r < 8; r++) begin
      y = impl_y(m, 3'(r));
      y0_m[r] = y[0];
      df = y ^ {3{y[0]}};
      if (df != 0 && first_mm == 99) begin
        first_mm  = r;
        mm_mask_m = df;
      end
    end
    n_rows = (st && first_mm != 99) ? first_mm + 1 : 8;
    pass_m = !(first_mm < n_rows);
  endtask

  logic pend = 1'b0, armed = 1'b0;
  int   d = 0, busy_cnt = 0, done_at_d = -1;

  task automatic check_cycle();
    int end_d, ks, kv, mt;
    logic [7:0] tt;
    end_d = n_rows * 2;
    ks = (d / 2 < n_rows) ? d / 2 : n_rows;
    kv = (d / 2 < n_rows - 1) ? d / 2 : n_rows - 1;
    tt = '0;
    mt = 0;
    for (int r = 0; r < ks; r++) begin
      tt[r] = y0_m[r];
      mt += int'(y0_m[r]);
    end
    chk("busy", 64'(busy), 64'(d < end_d));
    chk("done", 64'(done), 64'(d == end_d));
    chk("vec", 64'(vec), 64'(kv));
    chk("truth_table", 64'(truth_table), 64'(tt));
    chk("minterm_cnt", 64'(minterm_cnt), 64'(mt));
    chk("mismatch_vec", 64'(mismatch_vec), (first_mm < ks) ? 64'(first_mm) : 64'd0);
    chk("mismatch_mask", 64'(mismatch_mask), (first_mm < ks) ? 64'(mm_mask_m) : 64'd0);
    if (d != end_d) chk("pass", 64'(pass), (d > end_d) ? 64'(pass_m) : 64'd0);
  endtask

  // Compare process: d counts edges since the start-sampling edge t0.
  initial forever begin
    @(posedge clk);
    #1;
    if (pend) begin
      d = 0; armed = 1'b1; pend = 1'b0; busy_cnt = 0; done_at_d = -1;
    end else if (armed) begin
      d++;
    end
    if (armed) begin
      if (busy) busy_cnt++;
      if (done) done_at_d = d;
      check_cycle();
    end
  end

  task automatic do_start(input int m, input logic st);
    @(negedge clk);
    mode = m;
    stop_on_mismatch = st;
    compute_model(m, st);
    start = 1'b1;
    pend = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_results(input string tag, input logic [7:0] tt, input int mt,
                             input logic ps, input int mv, input logic [2:0] mm);
    chk({tag, ".truth_table"}, 64'(truth_table), 64'(tt));
    chk({tag, ".minterm_cnt"}, 64'(minterm_cnt), 64'(mt));
    chk({tag, ".pass"}, 64'(pass), 64'(ps));
    chk({tag, ".mismatch_vec"}, 64'(mismatch_vec), 64'(mv));
    chk({tag, ".mismatch_mask"}, 64'(mismatch_mask), 64'(mm));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".vec"}, 64'(vec), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk_results(tag, 8'h00, 0, 1'b0, 0, 3'b000);
    chk({tag, ".s_outs"}, 64'({busy_s, done_s, pass_s, mint_s, tt_s, vec_s, mvec_s, mmask_s}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop_on_mismatch = 1'b0; start_s = 1'b0; stop_s = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All implementations agree.
    do_start(0, 1'b0);
    repeat (18) @(negedge clk);
    chk_results("s1", 8'h8A, 3, 1'b1, 0, 3'b000);
    chk("s1.busy_cycles", 64'(busy_cnt), 64'd16);
    chk("s1.done_cycle", 64'(done_at_d + 1), 64'd17);

    // Impl 1 wrong at vec 1, full sweep.
    do_start(1, 1'b0);
    repeat (18) @(negedge clk);
    chk_results("s2", 8'h8A, 3, 1'b0, 1, 3'b010);

    // Same, stop at first mismatch.
    do_start(1, 1'b1);
    repeat (8) @(negedge clk);
    chk_results("s3", 8'h02, 1, 1'b0, 1, 3'b010);
    chk("s3.done_cycle", 64'(done_at_d + 1), 64'd5);

    // Impl 2 wrong only at vec 6, stop mode: model-checked sweep of 7 rows.
    do_start(2, 1'b1);
    repeat (16) @(negedge clk);
    chk_results("s4", 8'h0A, 2, 1'b0, 6, 3'b100);

    // Reset in the middle of the sweep at vec 4.
    do_start(0, 1'b0);
    repeat (8) @(negedge clk);
    chk("mid.vec_before_reset", 64'(vec), 64'd4);
    armed = 1'b0;
    rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_start(0, 1'b0);
    repeat (18) @(negedge clk);
    chk_results("after_reset", 8'h8A, 3, 1'b1, 0, 3'b000);

    // Start pulses while busy and during done must be ignored.
    do_start(0, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ign.done_now", 64'(done), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign.busy", 64'(busy), 64'd0);
    chk_results("ign", 8'h8A, 3, 1'b1, 0, 3'b000);

    // Minimal instance: one input, one implementation, no settle.
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("s.busy_d0", 64'({busy_s, done_s, vec_s}), 64'b100);
    @(negedge clk);
    chk("s.busy_d1", 64'({busy_s, done_s, vec_s}), 64'b101);
    @(negedge clk);
    chk("s.done_d2", 64'({busy_s, done_s}), 64'b01);
    @(negedge clk);
    chk("s.done_gone", 64'({busy_s, done_s}), 64'b00);
    chk("s.truth_table", 64'(tt_s), 64'b10);
    chk("s.minterm_cnt", 64'(mint_s), 64'd1);
    chk("s.pass", 64'(pass_s), 64'd1);
    chk("s.mismatch", 64'({mvec_s, mmask_s}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
